// File: rtl/pending_priority_arbiter.sv
// Sticky-pending request arbiter with mask and fixed/round-robin selection.
// The winner is offered as a registered grant on a valid/ready handshake.
module pending_priority_arbiter #(
   parameter int N   = 8,
   parameter int IDW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           enable,
   input  logic [N-1:0]   req,
   input  logic [N-1:0]   mask,
   input  logic           rr_mode,
   output logic           grant_valid,
   output logic [IDW-1:0] grant_id,
   input  logic           grant_ready,
   output logic [N-1:0]   pending,
   output logic           any_pending
);

   typedef enum logic {IDLE, OFFER} state_e;

   state_e         state_q, state_d;
   logic [N-1:0]   pending_q, pending_d;
   logic [IDW-1:0] grant_id_q, grant_id_d;
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

   logic           accept;
   logic [N-1:0]   accept_bit;
   logic [N-1:0]   elig;
   logic           sel_valid;
   logic [IDW-1:0] sel_id;

   always_comb begin
      accept     = (state_q == OFFER) && grant_ready;
      accept_bit = '0;
      for (int i = 0; i < N; i++) begin
         accept_bit[i] = accept && (grant_id_q == IDW'(i));
      end
      elig = pending_q & mask & ~accept_bit;
   end

   // Fixed mode keeps the last (highest) hit; RR keeps the first hit after rr_ptr.
   always_comb begin
      int idx;
      idx       = 0;
      sel_valid = 1'b0;
      sel_id    = '0;
      if (!rr_mode) begin
         for (int i = 0; i < N; i++) begin
            if (elig[i]) begin
               sel_valid = 1'b1;
               sel_id    = IDW'(i);
            end
         end
      end else begin
         for (int k = 1; k <= N; k++) begin
            idx = (int'(rr_ptr_q) + k) % N;
            if (!sel_valid && elig[idx]) begin
               sel_valid = 1'b1;
               sel_id    = IDW'(idx);
            end
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_id_d = grant_id_q;
      rr_ptr_d   = rr_ptr_q;
      pending_d  = (pending_q & ~accept_bit) | (enable ? req : '0);
      if (accept) begin
         rr_ptr_d = grant_id_q;
      end
      unique case (state_q)
         IDLE: begin
            if (enable && sel_valid) begin
               grant_id_d = sel_id;
               state_d    = OFFER;
            end
         end
         OFFER: begin
            if (grant_ready) begin
               if (enable && sel_valid) begin
                  grant_id_d = sel_id;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         pending_q  <= '0;
         grant_id_q <= '0;
         rr_ptr_q   <= IDW'(N - 1);
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         grant_id_q <= grant_id_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   assign grant_valid = (state_q == OFFER);
   assign grant_id    = grant_id_q;
   assign pending     = pending_q;
   assign any_pending = |(pending_q & mask);

endmodule

// File: tb/tb_pending_priority_arbiter.sv
// Scoreboard bench for pending_priority_arbiter: directed scenarios plus
// random traffic checked against a behavioural arbiter model.
module tb_pending_priority_arbiter;

   localparam int N   = 8;
   localparam int IDW = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic           enable;
   logic [N-1:0]   req;
   logic [N-1:0]   mask;
   logic           rr_mode;
   logic           grant_valid;
   logic [IDW-1:0] grant_id;
   logic           grant_ready;
   logic [N-1:0]   pending;
   logic           any_pending;

   int errors = 0;
   int checks = 0;
   bit armed  = 0;

   int exp_q[$];
   bit m_pend[N];
   bit m_valid;
   int m_id;
   int m_ptr;

   always #5 clk = ~clk;

   pending_priority_arbiter #(.N(N), .IDW(IDW)) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .req         (req),
      .mask        (mask),
      .rr_mode     (rr_mode),
      .grant_valid (grant_valid),
      .grant_id    (grant_id),
      .grant_ready (grant_ready),
      .pending     (pending),
      .any_pending (any_pending)
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] mpack();
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = m_pend[i];
      return v;
   endfunction

   // Candidates listed in priority order; the winner is the first one.
   function automatic int pick();
      int cand[$];
      bit acc;
      acc = m_valid && grant_ready;
      if (!rr_mode) begin
         for (int i = N - 1; i >= 0; i--) cand.push_back(i);
      end else begin
         for (int k = 1; k <= N; k++) cand.push_back((m_ptr + k) % N);
      end
      foreach (cand[j]) begin
         int b;
         b = cand[j];
         if (m_pend[b] && mask[b] && !(acc && m_id == b)) return b;
      end
      return -1;
   endfunction

   task automatic model_step();
      int s;
      bit acc;
      if (rst) begin
         foreach (m_pend[i]) m_pend[i] = 0;
         m_valid = 0;
         m_id    = 0;
         m_ptr   = N - 1;
         exp_q.delete();
         return;
      end
      acc = m_valid && grant_ready;
      s   = pick();
      if (acc) begin
         m_pend[m_id] = 0;
         m_ptr        = m_id;
      end
      if (enable) for (int i = 0; i < N; i++) if (req[i]) m_pend[i] = 1;
      if (!m_valid || acc) begin
         if (enable && s >= 0) begin
            m_valid = 1;
            m_id    = s;
            exp_q.push_back(s);
         end else begin
            m_valid = 0;
         end
      end
   endtask

   task automatic cyc(input bit r, input bit e, input logic [N-1:0] rq,
                      input logic [N-1:0] mk, input bit rr, input bit rd);
      rst         = r;
      enable      = e;
      req         = rq;
      mask        = mk;
      rr_mode     = rr;
      grant_ready = rd;
      @(posedge clk);
      model_step();
      #1;
   endtask

   always @(negedge clk) begin
      if (armed) begin
         chk("pending", int'(pending), int'(mpack()));
         chk("grant_valid", int'(grant_valid), int'(m_valid));
         chk("any_pending", int'(any_pending), int'(|(mpack() & mask)));
         if (m_valid) chk("grant_id_hold", int'(grant_id), m_id);
         if (grant_valid && grant_ready && !rst) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: got grant %0d expected none", grant_id);
            end else begin
               chk("sb_grant", int'(grant_id), exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      logic [N-1:0] rq, mk;
      bit rr;
      rr = 0;
      mk = '1;

      cyc(1, 0, '0, '1, 0, 0);
      cyc(1, 0, '0, '1, 0, 0);
      armed = 1;
      chk("rst_valid", int'(grant_valid), 0);
      chk("rst_id", int'(grant_id), 0);
      chk("rst_pend", int'(pending), 0);

      // Fixed priority: 5 then 2 back-to-back
      cyc(0, 1, 8'h24, '1, 0, 1);
      chk("t1_pend", int'(pending), 'h24);
      chk("t1_valid0", int'(grant_valid), 0);
      cyc(0, 1, 8'h00, '1, 0, 1);
      chk("t1_id5", int'(grant_id), 5);
      chk("t1_valid1", int'(grant_valid), 1);
      cyc(0, 1, 8'h00, '1, 0, 1);
      chk("t1_id2", int'(grant_id), 2);
      cyc(0, 1, 8'h00, '1, 0, 1);
      chk("t1_idle", int'(grant_valid), 0);
      chk("t1_pend0", int'(pending), 0);

      // Offered grant held against a higher request
      cyc(0, 1, 8'h04, '1, 0, 0);
      cyc(0, 1, 8'h00, '1, 0, 0);
      cyc(0, 1, 8'h80, '1, 0, 0);
      chk("t2_hold", int'(grant_id), 2);
      cyc(0, 1, 8'h00, '1, 0, 0);
      chk("t2_hold2", int'(grant_id), 2);
      cyc(0, 1, 8'h00, '1, 0, 1);
      chk("t2_next7", int'(grant_id), 7);
      cyc(0, 1, 8'h00, '1, 0, 1);

      // Round robin 0..7
      cyc(0, 1, 8'hFF, '1, 1, 1);
      for (int k = 0; k < N; k++) begin
         cyc(0, 1, 8'h00, '1, 1, 1);
         chk("t3_rr", int'(grant_id), k);
      end
      cyc(0, 1, 8'h00, '1, 1, 1);
      chk("t3_idle", int'(grant_valid), 0);

      // Masked bit stays pending
      cyc(0, 1, 8'h81, 8'h01, 0, 1);
      cyc(0, 1, 8'h00, 8'h01, 0, 1);
      chk("t4_id0", int'(grant_id), 0);
      cyc(0, 1, 8'h00, 8'h01, 0, 1);
      chk("t4_pend80", int'(pending), 'h80);
      chk("t4_idle", int'(grant_valid), 0);
      cyc(0, 1, 8'h00, 8'hFF, 0, 1);
      chk("t4_id7", int'(grant_id), 7);
      cyc(0, 1, 8'h00, 8'hFF, 0, 1);

      // Set wins over clear
      cyc(0, 1, 8'h08, '1, 0, 1);
      cyc(0, 1, 8'h08, '1, 0, 1);
      chk("t5_id3", int'(grant_id), 3);
      cyc(0, 1, 8'h08, '1, 0, 1);
      chk("t5_pend", int'(pending), 'h08);
      cyc(0, 1, 8'h00, '1, 0, 1);
      chk("t5_regrant", int'(grant_id), 3);
      chk("t5_valid", int'(grant_valid), 1);
      cyc(0, 1, 8'h00, '1, 0, 1);

      // Reset during offer, then enable=0
      cyc(0, 1, 8'h04, '1, 0, 0);
      cyc(0, 1, 8'h00, '1, 0, 0);
      cyc(1, 1, 8'h00, '1, 0, 0);
      chk("t6_valid", int'(grant_valid), 0);
      chk("t6_pend", int'(pending), 0);
      for (int k = 0; k < 3; k++) cyc(0, 0, 8'hFF, '1, 0, 1);
      chk("t6_en_pend", int'(pending), 0);
      chk("t6_en_valid", int'(grant_valid), 0);
      cyc(0, 1, 8'h81, '1, 1, 0);
      cyc(0, 1, 8'h00, '1, 1, 0);
      chk("t6_rrptr", int'(grant_id), 0);

      // Random traffic
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 15) == 0) rr = ~rr;
         if ($urandom_range(0, 7) == 0) mk = ($urandom_range(0, 1) != 0) ? '1 : N'($urandom);
         rq = N'($urandom & $urandom & $urandom);
         cyc($urandom_range(0, 99) == 0, $urandom_range(0, 4) != 0, rq, mk, rr,
             $urandom_range(0, 9) < 6);
      end

      // Drain any offered grant
      for (int k = 0; k < 3; k++) cyc(0, 0, '0, '1, 0, 1);
      chk("drain_q", exp_q.size(), 0);
      chk("drain_valid", int'(grant_valid), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
